// File: rtl/y86_fetch_ctrl.sv
// rtl/y86_fetch_ctrl.sv - Y86-64 fetch requester: issues pc, captures the 10-byte window,
// splits fields, computes valP/stat and presents one instruction at a time to decode.
module y86_fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc,
  input  logic        imem_error,
  input  logic [7:0]  byte0,
  input  logic [71:0] byte19,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [1:0]  stat,
  input  logic        pc_upd_valid,
  input  logic [63:0] pc_upd,
  output logic        halted
);

  typedef enum logic [2:0] {REQ, CAP, PRESENT, NEXTPC, STOP} state_t;

  localparam logic [1:0]  STAT_AOK = 2'd0;
  localparam logic [1:0]  STAT_HLT = 2'd1;
  localparam logic [1:0]  STAT_ADR = 2'd2;
  localparam logic [1:0]  STAT_INS = 2'd3;
  localparam logic [64:0] LAST_ADDR = 65'(MEM_BYTES - 1);

  state_t state, state_nx;

  logic [3:0]  d_icode, d_ifun, d_ra, d_rb, d_len;
  logic        need_regids, need_valc, legal, adr;
  logic [63:0] d_valc;
  logic [64:0] end_addr;
  logic [1:0]  d_stat;

  always_comb begin
    d_icode     = byte0[7:4];
    d_ifun      = byte0[3:0];
    need_regids = 1'b0;
    need_valc   = 1'b0;
    legal       = 1'b0;
    d_valc      = '0;
    case (d_icode)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      default: need_regids = 1'b0;
    endcase
    case (d_icode)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
      default: need_valc = 1'b0;
    endcase
    case (d_icode)
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: legal = (d_ifun == 4'd0);
      4'h2, 4'h7: legal = (d_ifun <= 4'd6);
      4'h6:       legal = (d_ifun <= 4'd3);
      default:    legal = 1'b0;
    endcase
    d_ra = need_regids ? byte19[71:68] : 4'hF;
    d_rb = need_regids ? byte19[67:64] : 4'hF;
    // valC is little-endian and starts right after the opcode or the register byte
    if (need_valc) begin
      for (int i = 0; i < 8; i++) begin
        d_valc[8*i +: 8] = need_regids ? byte19[63-8*i -: 8] : byte19[71-8*i -: 8];
      end
    end
    d_len    = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
    // 65-bit so an instruction straddling 2^64 is still flagged instead of wrapping
    end_addr = {1'b0, pc} + {61'b0, d_len} - 65'd1;
    adr      = imem_error || (end_addr > LAST_ADDR) || ({1'b0, pc} > LAST_ADDR);
    if (adr)                  d_stat = STAT_ADR;
    else if (!legal)          d_stat = STAT_INS;
    else if (d_icode == 4'h0) d_stat = STAT_HLT;
    else                      d_stat = STAT_AOK;
  end

  always_comb begin
    state_nx = state;
    case (state)
      REQ:     state_nx = CAP;
      CAP:     state_nx = PRESENT;
      PRESENT: if (f_ready) state_nx = (stat != STAT_AOK) ? STOP : NEXTPC;
      NEXTPC:  if (pc_upd_valid) state_nx = REQ;
      STOP:    state_nx = STOP;
      default: state_nx = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REQ;
      pc    <= RESET_PC;
      icode <= 4'h0;
      ifun  <= 4'h0;
      rA    <= 4'hF;
      rB    <= 4'hF;
      valC  <= '0;
      valP  <= '0;
      stat  <= STAT_AOK;
    end else begin
      state <= state_nx;
      if (state == NEXTPC && pc_upd_valid) pc <= pc_upd;
      if (state == CAP) begin
        icode <= d_icode;
        ifun  <= d_ifun;
        rA    <= d_ra;
        rB    <= d_rb;
        valC  <= d_valc;
        valP  <= pc + {60'b0, d_len};
        stat  <= d_stat;
      end
    end
  end

  assign f_valid = (state == PRESENT);
  assign halted  = (state == STOP);

endmodule

// File: tb/tb_y86_fetch_ctrl.sv
// tb/tb_y86_fetch_ctrl.sv - directed and randomized fetch sequences checked against
// an instruction-level reference model with a byte-array instruction memory.
module tb_y86_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc;
  logic        imem_error = 1'b0;
  logic [7:0]  byte0;
  logic [71:0] byte19;
  logic        f_valid;
  logic        f_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [1:0]  stat;
  logic        pc_upd_valid = 1'b0;
  logic [63:0] pc_upd = '0;
  logic        halted;

  int vecs = 0;
  int miss = 0;

  logic [7:0] mem [0:2047];

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [1:0]  stat;
  } exp_t;

  y86_fetch_ctrl #(.RESET_PC(64'd0), .MEM_BYTES(2048)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .imem_error(imem_error),
    .byte0(byte0), .byte19(byte19), .f_valid(f_valid), .f_ready(f_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .stat(stat), .pc_upd_valid(pc_upd_valid), .pc_upd(pc_upd), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return (a < 64'd2048) ? mem[a[10:0]] : 8'h00;
  endfunction

  // pc is stable from REQ through CAP, so a combinational read models the 1-cycle memory
  always_comb begin
    byte0 = rd(pc);
    for (int i = 1; i <= 9; i++) byte19[8*(9-i) +: 8] = rd(pc + 64'(i));
  end

  function automatic exp_t model(input logic [63:0] a, input logic err);
    exp_t e;
    logic [7:0] b [10];
    int maxf [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
    logic [15:0] regs_mask = 16'h0C7C;
    logic [15:0] valc_mask = 16'h01B8;
    int r, c, len, start;
    logic [64:0] last_byte;
    for (int i = 0; i < 10; i++) b[i] = rd(a + 64'(i));
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    r = int'(regs_mask[e.icode]);
    c = int'(valc_mask[e.icode]);
    e.ra = r ? b[1][7:4] : 4'hF;
    e.rb = r ? b[1][3:0] : 4'hF;
    e.valc = '0;
    start = 1 + r;
    if (c != 0) for (int i = 0; i < 8; i++) e.valc = e.valc | (64'(b[start+i]) << (8*i));
    len = 1 + r + 8*c;
    e.valp = a + 64'(len);
    last_byte = 65'(a) + 65'(len) - 65'd1;
    if (err || a > 64'd2047 || last_byte > 65'd2047) e.stat = 2'd2;
    else if (maxf[e.icode] < 0 || int'(e.ifun) > maxf[e.icode]) e.stat = 2'd3;
    else if (e.icode == 4'h0) e.stat = 2'd1;
    else e.stat = 2'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input exp_t e);
    chk({tag, ".f_valid"}, 64'(f_valid), 64'd1);
    chk({tag, ".icode"}, 64'(icode), 64'(e.icode));
    chk({tag, ".ifun"}, 64'(ifun), 64'(e.ifun));
    chk({tag, ".rA"}, 64'(rA), 64'(e.ra));
    chk({tag, ".rB"}, 64'(rB), 64'(e.rb));
    chk({tag, ".valC"}, valC, e.valc);
    chk({tag, ".valP"}, valP, e.valp);
    chk({tag, ".stat"}, 64'(stat), 64'(e.stat));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!f_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic place(input logic [63:0] a, input logic [79:0] bytes);
    for (int i = 0; i < 10; i++)
      if (a + 64'(i) < 64'd2048) mem[a[10:0] + 11'(i)] = bytes[79-8*i -: 8];
  endtask

  task automatic accept(input string tag, input logic [63:0] a);
    @(negedge clk);
    f_ready = 1'b1;
    pc_upd_valid = 1'b1;
    pc_upd = a ^ 64'h55;
    @(posedge clk); #1;
    f_ready = 1'b0;
    pc_upd_valid = 1'b0;
    chk({tag, ".drop"}, 64'(f_valid), 64'd0);
    chk({tag, ".pc_hold"}, pc, a);
  endtask

  task automatic do_reset(input string tag);
    int n;
    mem[0] = 8'h10;
    imem_error = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".rst_pc"}, pc, 64'd0);
    chk({tag, ".rst_fv"}, 64'(f_valid), 64'd0);
    chk({tag, ".rst_halted"}, 64'(halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    chk({tag, ".rst_lat"}, 64'(n), 64'd2);
    chk({tag, ".rst_icode"}, 64'(icode), 64'd1);
    chk({tag, ".rst_valP"}, valP, 64'd1);
    accept(tag, 64'd0);
  endtask

  // Entry precondition: DUT waiting in NEXTPC.
  task automatic fetch(input string tag, input logic [63:0] a, input logic err, input int hold);
    exp_t e;
    int n;
    imem_error = err;
    e = model(a, err);
    @(negedge clk);
    pc_upd = a;
    pc_upd_valid = 1'b1;
    @(posedge clk); #1;
    pc_upd_valid = 1'b0;
    pc_upd = ~a;
    chk({tag, ".pc"}, pc, a);
    wait_valid(n);
    chk({tag, ".lat"}, 64'(n), 64'd2);
    chk_fields(tag, e);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk_fields({tag, ".hold"}, e);
    end
    accept(tag, a);
    imem_error = 1'b0;
    chk({tag, ".halted"}, 64'(halted), 64'(e.stat != 2'd0));
    if (e.stat != 2'd0) begin
      for (int p = 0; p < 3; p++) begin
        @(negedge clk);
        pc_upd_valid = 1'b1;
        pc_upd = 64'($urandom);
        @(posedge clk); #1;
        pc_upd_valid = 1'b0;
        chk({tag, ".stop_pc"}, pc, a);
        chk({tag, ".stop_fv"}, 64'(f_valid), 64'd0);
      end
      do_reset(tag);
    end
  endtask

  initial begin
    int n;
    logic [3:0]  ic, fn;
    logic [63:0] a;
    logic [79:0] rb;
    logic [3:0]  legal_ic [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h0};
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[0] = 8'h10;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pc, 64'd0);
    chk("reset.f_valid", 64'(f_valid), 64'd0);
    chk("reset.icode", 64'(icode), 64'd0);
    chk("reset.ifun", 64'(ifun), 64'd0);
    chk("reset.rA", 64'(rA), 64'hF);
    chk("reset.rB", 64'(rB), 64'hF);
    chk("reset.valC", valC, 64'd0);
    chk("reset.valP", valP, 64'd0);
    chk("reset.stat", 64'(stat), 64'd0);
    chk("reset.halted", 64'(halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    chk("boot.lat", 64'(n), 64'd2);
    chk("boot.icode", 64'(icode), 64'd1);
    accept("boot", 64'd0);

    place(64'd112, 80'h30F8_0400_0000_0000_0000);
    fetch("irmovq", 64'd112, 1'b0, 3);
    chk("irmovq.valC_const", valC, 64'd4);
    chk("irmovq.valP_const", valP, 64'd122);
    place(64'd133, 80'h7066_1000_0000_0000_0000);
    fetch("jmp", 64'd133, 1'b0, 0);
    chk("jmp.valC_const", valC, 64'h1066);
    place(64'd132, 80'h6300_0000_0000_0000_0000);
    fetch("opq", 64'd132, 1'b0, 0);
    chk("opq.valP_const", valP, 64'd134);
    place(64'd2040, 80'h30F8_0400_0000_0000_0000);
    fetch("adr_2040", 64'd2040, 1'b0, 0);
    place(64'd2047, 80'h1000_0000_0000_0000_0000);
    fetch("nop_2047", 64'd2047, 1'b0, 0);
    fetch("err_3000", 64'd3000, 1'b1, 0);
    place(64'd200, 80'hC000_0000_0000_0000_0000);
    fetch("ins_c0", 64'd200, 1'b0, 0);
    place(64'd210, 80'h2612_0000_0000_0000_0000);
    fetch("cmov6", 64'd210, 1'b0, 0);
    place(64'd220, 80'h6412_0000_0000_0000_0000);
    fetch("ins_64", 64'd220, 1'b0, 0);
    place(64'd230, 80'h0000_0000_0000_0000_0000);
    fetch("halt", 64'd230, 1'b0, 0);

    // reset while an instruction is being presented: it must be dropped, not re-presented
    place(64'd112, 80'h30F8_0400_0000_0000_0000);
    @(negedge clk);
    pc_upd = 64'd112;
    pc_upd_valid = 1'b1;
    @(posedge clk); #1;
    pc_upd_valid = 1'b0;
    wait_valid(n);
    chk("rst_present.lat", 64'(n), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_present.f_valid", 64'(f_valid), 64'd0);
    chk("rst_present.pc", pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    chk("rst_present.refetch_lat", 64'(n), 64'd2);
    chk("rst_present.refetch_icode", 64'(icode), 64'd1);
    accept("rst_present", 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_present.no_repeat", 64'(f_valid), 64'd0);
    end

    for (int t = 0; t < 40; t++) begin
      a  = 64'($urandom_range(16, 2100));
      ic = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal_ic[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      rb = {ic, fn, 32'($urandom), 32'($urandom), 8'($urandom)};
      place(a, rb);
      fetch("rand", a, ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
